// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: stage indices, the result-ready stage per instruction type
// and a constant-foldable clog2 used to size stage-index fields.
package pipeline_pkg;

   localparam int STAGE_EXE = 0;
   localparam int STAGE_MEM = 1;

   typedef enum logic [1:0] {
      INSN_ALU      = 2'd0,
      INSN_LOAD_IMM = 2'd1,
      INSN_LOAD_MEM = 2'd2
   } insn_kind_e;

   localparam int RDY_ALU      = STAGE_EXE;
   localparam int RDY_LOAD_IMM = STAGE_EXE;
   localparam int RDY_LOAD_MEM = STAGE_MEM;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int ready_stage_of(input insn_kind_e kind);
      case (kind)
         INSN_LOAD_MEM: return RDY_LOAD_MEM;
         INSN_LOAD_IMM: return RDY_LOAD_IMM;
         default:       return RDY_ALU;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_if.sv
// Issue request and hazard-resolution response between the issue register (master)
// and the hazard scoreboard (slave); all responses are combinational in the same cycle.
interface pipeline_hazard_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2,
   parameter int SW       = 2
);
   logic                       issue_valid;
   logic                       issue_dst_valid;
   logic [ADDR_W-1:0]          issue_dst;
   logic [SW-1:0]              issue_ready_stage;
   logic [NUM_READ-1:0]        issue_src_valid;
   logic [NUM_READ*ADDR_W-1:0] issue_src;
   logic                       squash;
   logic                       flush;
   logic                       stall;
   logic [NUM_READ-1:0]        fwd_hit;
   logic [NUM_READ*SW-1:0]     fwd_stage;
   logic [NUM_REGS-1:0]        busy;
   logic [31:0]                stall_count;

   modport master (
      output issue_valid, issue_dst_valid, issue_dst, issue_ready_stage,
      output issue_src_valid, issue_src, squash, flush,
      input  stall, fwd_hit, fwd_stage, busy, stall_count
   );

   modport slave (
      input  issue_valid, issue_dst_valid, issue_dst, issue_ready_stage,
      input  issue_src_valid, issue_src, squash, flush,
      output stall, fwd_hit, fwd_stage, busy, stall_count
   );

endinterface

// File: rtl/scoreboard_port_match.sv
// Priority match of one source register against the in-flight entry vector; the youngest
// matching entry decides between bypass (result already produced) and hazard. Purely combinational.
module scoreboard_port_match #(
   parameter int ADDR_W     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int SW         = 2,
   parameter int R0_ZERO    = 0
) (
   input  logic                         src_vld,
   input  logic [ADDR_W-1:0]            src,
   input  logic [PIPE_DEPTH-1:0]        ent_v,
   input  logic [PIPE_DEPTH*ADDR_W-1:0] ent_dst,
   input  logic [PIPE_DEPTH*SW-1:0]     ent_rdy,
   output logic                         hazard,
   output logic                         hit,
   output logic [SW-1:0]                stage
);

   logic src_live;
   logic found;

   assign src_live = src_vld && !((R0_ZERO != 0) && (src == '0));

   // Stage 0 is the youngest entry, so the first match in ascending order shadows older writers.
   always_comb begin
      hazard = 1'b0;
      hit    = 1'b0;
      stage  = '0;
      found  = 1'b0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         if (src_live && !found && ent_v[k] && (ent_dst[k*ADDR_W +: ADDR_W] == src)) begin
            found = 1'b1;
            if (SW'(k) >= ent_rdy[k*SW +: SW]) begin
               hit   = 1'b1;
               stage = SW'(k);
            end else begin
               hazard = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations from issue to write-back and resolves each
// read port into bypass, stall or register-file read in the same cycle; downstream never stalls.
module pipeline_hazard_scoreboard
   import pipeline_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_W     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int NUM_READ   = 2,
   parameter int R0_ZERO    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   pipeline_hazard_scoreboard_if.slave sb
);

   localparam int SW = (clog2(PIPE_DEPTH) > 1) ? clog2(PIPE_DEPTH) : 1;

   logic [PIPE_DEPTH-1:0]             v_q, v_d;
   logic [PIPE_DEPTH-1:0][ADDR_W-1:0] dst_q, dst_d;
   logic [PIPE_DEPTH-1:0][SW-1:0]     rdy_q, rdy_d;
   logic [31:0]                       stall_count_q, stall_count_d;

   logic [NUM_READ-1:0]               port_hazard;
   logic [NUM_READ-1:0]               port_hit;
   logic [NUM_READ-1:0][SW-1:0]       port_stage;
   logic                              stall;
   logic                              dst_is_zero;
   logic                              load_v;
   logic [NUM_REGS-1:0]               busy_vec;

   for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      scoreboard_port_match #(
         .ADDR_W    (ADDR_W),
         .PIPE_DEPTH(PIPE_DEPTH),
         .SW        (SW),
         .R0_ZERO   (R0_ZERO)
      ) u_match (
         .src_vld (sb.issue_src_valid[p]),
         .src     (sb.issue_src[p*ADDR_W +: ADDR_W]),
         .ent_v   (v_q),
         .ent_dst (dst_q),
         .ent_rdy (rdy_q),
         .hazard  (port_hazard[p]),
         .hit     (port_hit[p]),
         .stage   (port_stage[p])
      );
   end

   assign stall       = sb.issue_valid & (|port_hazard);
   assign dst_is_zero = (R0_ZERO != 0) && (sb.issue_dst == '0);
   // A stalled or squashed instruction becomes a bubble in stage 0.
   assign load_v      = sb.issue_valid & sb.issue_dst_valid & ~stall & ~sb.squash & ~dst_is_zero;

   always_comb begin
      v_d      = '0;
      dst_d    = '0;
      rdy_d    = '0;
      v_d[0]   = load_v;
      dst_d[0] = sb.issue_dst;
      rdy_d[0] = sb.issue_ready_stage;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         v_d[k]   = v_q[k-1];
         dst_d[k] = dst_q[k-1];
         rdy_d[k] = rdy_q[k-1];
      end
      if (sb.flush) begin
         v_d = '0;
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_comb begin
      busy_vec = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         if (v_q[k] && (int'(dst_q[k]) < NUM_REGS)) begin
            busy_vec[dst_q[k]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q           <= '0;
         dst_q         <= '0;
         rdy_q         <= '0;
         stall_count_q <= '0;
      end else begin
         v_q           <= v_d;
         dst_q         <= dst_d;
         rdy_q         <= rdy_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign sb.stall       = stall;
   assign sb.fwd_hit     = port_hit;
   assign sb.fwd_stage   = port_stage;
   assign sb.busy        = busy_vec;
   assign sb.stall_count = stall_count_q;

   a_ready_stage_legal: assert property (@(posedge clk) disable iff (!rst)
      (sb.issue_valid && sb.issue_dst_valid) |-> (int'(sb.issue_ready_stage) <= PIPE_DEPTH - 1));

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Randomised and directed stimulus against a queue-of-in-flight-writers reference model;
// expectations are queued by the driver and popped by an independent monitor on the falling edge.
module tb_pipeline_hazard_scoreboard;
   import pipeline_pkg::*;

   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 3;
   localparam int NRD   = 2;
   localparam int SWB   = 2;

   typedef struct {
      bit       iv;
      bit       dv;
      bit [4:0] dst;
      bit [1:0] rs;
      bit [1:0] sv;
      bit [4:0] s0;
      bit [4:0] s1;
      bit       sq;
      bit       fl;
   } stim_t;

   typedef struct {
      bit        stall;
      bit [1:0]  hit;
      bit [3:0]  stage;
      bit [31:0] busy;
      bit [31:0] cnt;
   } exp_t;

   typedef struct {
      int dst;
      int rdy;
      int age;
   } flight_t;

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   int        checks = 0;
   int        failures = 0;
   exp_t      exp_q[$];
   flight_t   flight[$];
   bit [31:0] model_cnt = 32'd0;
   stim_t     cur;
   bit        cur_stall = 1'b0;
   int        r_alu;
   int        r_ld;

   pipeline_hazard_scoreboard_if #(.NUM_REGS(NREG), .ADDR_W(AW), .NUM_READ(NRD), .SW(SWB)) sbif ();

   pipeline_hazard_scoreboard #(
      .NUM_REGS  (NREG),
      .ADDR_W    (AW),
      .PIPE_DEPTH(DEPTH),
      .NUM_READ  (NRD),
      .R0_ZERO   (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sb (sbif)
   );

   always #5 clk = ~clk;

   function automatic stim_t mk(bit iv, bit dv, int dst, int rs, bit [1:0] sv, int s0, int s1,
                                bit sq = 1'b0, bit fl = 1'b0);
      stim_t s;
      s.iv = iv; s.dv = dv; s.dst = 5'(dst); s.rs = 2'(rs);
      s.sv = sv; s.s0 = 5'(s0); s.s1 = 5'(s1); s.sq = sq; s.fl = fl;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.iv  = ($urandom_range(0, 3) != 0);
      s.dv  = 1'($urandom_range(0, 1));
      s.dst = 5'($urandom_range(0, 7));
      s.rs  = 2'($urandom_range(0, 2));
      s.sv  = 2'($urandom_range(0, 3));
      s.s0  = 5'($urandom_range(0, 7));
      s.s1  = 5'($urandom_range(0, 7));
      s.sq  = ($urandom_range(0, 7) == 0);
      s.fl  = ($urandom_range(0, 15) == 0);
      return s;
   endfunction

   // Youngest in-flight writer of a source decides: produced already -> bypass, else stall.
   function automatic exp_t predict(stim_t s);
      exp_t e;
      bit   haz;
      int   src;
      int   best;
      e = '{stall: 1'b0, hit: 2'b0, stage: 4'b0, busy: 32'b0, cnt: model_cnt};
      haz = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         src  = (p == 0) ? int'(s.s0) : int'(s.s1);
         best = -1;
         if (s.sv[p] && src != 0) begin
            foreach (flight[i]) begin
               if (flight[i].dst == src && (best < 0 || flight[i].age < flight[best].age)) best = i;
            end
         end
         if (best >= 0) begin
            if (flight[best].age >= flight[best].rdy) begin
               e.hit[p]         = 1'b1;
               e.stage[2*p +: 2] = 2'(flight[best].age);
            end else begin
               haz = 1'b1;
            end
         end
      end
      e.stall = s.iv && haz;
      foreach (flight[i]) e.busy[flight[i].dst] = 1'b1;
      return e;
   endfunction

   task automatic model_advance();
      flight_t nxt[$];
      if (cur_stall && model_cnt != 32'hFFFF_FFFF) model_cnt++;
      if (!cur.fl) begin
         foreach (flight[i]) begin
            if (flight[i].age + 1 < DEPTH)
               nxt.push_back('{dst: flight[i].dst, rdy: flight[i].rdy, age: flight[i].age + 1});
         end
         if (cur.iv && cur.dv && !cur_stall && !cur.sq && cur.dst != 5'd0)
            nxt.push_back('{dst: int'(cur.dst), rdy: int'(cur.rs), age: 0});
      end
      flight = nxt;
   endtask

   task automatic apply(stim_t s);
      exp_t e;
      cur = s;
      sbif.issue_valid       = s.iv;
      sbif.issue_dst_valid   = s.dv;
      sbif.issue_dst         = s.dst;
      sbif.issue_ready_stage = s.rs;
      sbif.issue_src_valid   = s.sv;
      sbif.issue_src         = {s.s1, s.s0};
      sbif.squash            = s.sq;
      sbif.flush             = s.fl;
      e = predict(s);
      cur_stall = e.stall;
      exp_q.push_back(e);
   endtask

   task automatic step(stim_t s);
      @(posedge clk);
      #1;
      if (rst) model_advance();
      apply(s);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 2'b00, 0, 0));
   endtask

   // Reset lands mid-cycle, well away from any clock edge, so its effect is purely asynchronous.
   task automatic reset_mid(int hold);
      @(posedge clk);
      #1;
      if (rst) model_advance();
      #2;
      rst = 1'b0;
      flight.delete();
      model_cnt = 32'd0;
      exp_q.delete();
      apply(mk(0, 0, 0, 0, 2'b00, 0, 0));
      repeat (hold) begin
         @(posedge clk);
         #1;
         apply(mk(0, 0, 0, 0, 2'b00, 0, 0));
      end
      release_reset();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",       32'(sbif.stall),       32'(e.stall));
            chk("fwd_hit",     32'(sbif.fwd_hit),     32'(e.hit));
            chk("fwd_stage",   32'(sbif.fwd_stage),   32'(e.stage));
            chk("busy",        sbif.busy,             e.busy);
            chk("stall_count", sbif.stall_count,      e.cnt);
         end
      end
   end

   initial begin
      r_alu = ready_stage_of(INSN_ALU);
      r_ld  = ready_stage_of(INSN_LOAD_MEM);
      apply(mk(0, 0, 0, 0, 2'b00, 0, 0));
      exp_q.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
         apply(mk(0, 0, 0, 0, 2'b00, 0, 0));
      end
      release_reset();

      // ALU -> ALU chain: bypass from stage 0, 1, 2, then the register file.
      step(mk(1, 1, 3, r_alu, 2'b00, 0, 0));
      repeat (4) step(mk(1, 0, 0, 0, 2'b01, 3, 0));

      // Load-use on port 1: one stall, then bypass from MEM.
      step(mk(1, 1, 5, r_ld, 2'b00, 0, 0));
      repeat (2) step(mk(1, 0, 0, 0, 2'b10, 0, 5));
      step(mk(0, 0, 0, 0, 2'b00, 0, 0));

      // Younger ALU writer hides the older unready load.
      step(mk(1, 1, 7, r_ld, 2'b00, 0, 0));
      step(mk(1, 1, 7, r_alu, 2'b00, 0, 0));
      step(mk(1, 0, 0, 0, 2'b01, 7, 0));

      // Squashed writer never becomes busy; flush empties the pipe.
      step(mk(1, 1, 9, r_alu, 2'b00, 0, 0, 1'b1));
      repeat (2) step(mk(1, 0, 0, 0, 2'b01, 9, 0));
      step(mk(1, 1, 11, r_alu, 2'b00, 0, 0));
      step(mk(1, 1, 12, r_ld, 2'b00, 0, 0));
      step(mk(1, 1, 13, r_alu, 2'b00, 0, 0));
      step(mk(0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b1));
      step(mk(1, 0, 0, 0, 2'b11, 11, 12));

      // Stall and squash together, and the hardwired-zero register.
      step(mk(1, 1, 14, r_ld, 2'b00, 0, 0));
      step(mk(1, 1, 15, r_alu, 2'b01, 14, 0, 1'b1));
      step(mk(1, 0, 0, 0, 2'b11, 15, 14));
      step(mk(1, 1, 0, r_alu, 2'b00, 0, 0));
      step(mk(1, 0, 0, 0, 2'b11, 0, 0));

      // Traffic, asynchronous reset mid-stream, then a reader of earlier writers.
      repeat (40) step(rnd());
      reset_mid(2);
      step(mk(1, 0, 0, 0, 2'b11, 3, 4));

      repeat (400) step(rnd());
      step(mk(0, 0, 0, 0, 2'b00, 0, 0));

      // Saturation: preload the counter just below the top, then stall four times.
      #5;
      force dut.stall_count_q = 32'hFFFF_FFFE;
      model_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_count_q;
      repeat (2) begin
         step(mk(1, 1, 10, 2, 2'b00, 0, 0));
         repeat (3) step(mk(1, 0, 0, 0, 2'b01, 10, 0));
      end
      step(mk(0, 0, 0, 0, 2'b00, 0, 0));

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
# pipeline_hazard_scoreboard

Parametrised hazard scoreboard for the in-order pipelined core. It sits beside the issue register and tracks every in-flight destination register from issue through write-back. Each cycle it produces a stall request plus per-read-port forwarding selects, and supports squash/flush for taken jumps. It replaces the fixed combinational stall detector with a sequential, depth- and port-count-generic unit that forwards when possible and stalls only when a producer's result is not yet available.

## Interface
- `NUM_REGS`, default 32: architectural registers.
- `ADDR_W`, default 5: register address width; `2**ADDR_W >= NUM_REGS`.
- `PIPE_DEPTH`, default 3: tracked stages after issue (EXE=0, MEM=1, WB=`PIPE_DEPTH-1`).
- `NUM_READ`, default 2: source read ports.
- `R0_ZERO`, default 0: 1 = register 0 is hardwired zero and is never tracked or matched.
- `SW`: localparam, `max(1, clog2(PIPE_DEPTH))`.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: a real (non-bubble) instruction sits in the issue register.
- `issue_dst_valid` in 1: that instruction writes a register.
- `issue_dst` in `ADDR_W`: destination register.
- `issue_ready_stage` in `SW`: first stage index whose output holds the result (ALU=0, load=1).
- `issue_src_valid` in `NUM_READ`: per-port source-used flags.
- `issue_src` in `NUM_READ*ADDR_W`: packed source addresses, port 0 in the LSBs.
- `squash` in 1: discard the instruction entering stage 0 this cycle (jump shadow).
- `flush` in 1: invalidate every in-flight entry.
- `stall` out 1: hold issue and PC; a bubble enters stage 0.
- `fwd_hit` out `NUM_READ`: per port, take the operand from the bypass, not the register file.
- `fwd_stage` out `NUM_READ*SW`: per port, the stage index to bypass from.
- `busy` out `NUM_REGS`: registers with a pending in-flight write.
- `stall_count` out 32: saturating count of stall cycles.

## Operation
- **State.** `PIPE_DEPTH` entries, each holding `{v, dst, rdy}`. Every entry shifts one stage per cycle unconditionally; downstream stages never stall.
- **Matching.** Port p matches entry k when all hold: `issue_src_valid[p]`, `v[k]`, `dst[k]==src[p]`, and not (`R0_ZERO` and `src[p]==0`). The lowest k (youngest) wins the priority.
- **Forward vs stall.** For the winning k:
  - if `k >= rdy[k]`: `fwd_hit[p]=1`, `fwd_stage[p]=k`;
  - otherwise port p raises a hazard.
  - An older match hidden behind a younger one is ignored.
- **Stall condition.** `stall = issue_valid & (OR of port hazards)`. Outputs are combinational from current state and issue inputs; `fwd_*` are also valid when `stall=1`.
- **Stage-0 entry load.** On posedge, stage 0 is loaded with `{issue_valid & issue_dst_valid & ~stall & ~squash & ~(R0_ZERO & dst==0), issue_dst, issue_ready_stage}`. Stage k loads from stage k-1. The entry leaving stage `PIPE_DEPTH-1` retires, because the register file has been written on that edge.
- **`busy[r]`.** OR over valid entries with `dst==r`.
- **Flush.** Clears all `v`, including the stage-0 load that edge. Takes priority over `squash`.
- **Counter.** `stall_count` increments on every cycle with `stall=1`, saturating at `32'hFFFF_FFFF`. Flush does not clear it.
- **Out-of-range issue.** `issue_ready_stage > PIPE_DEPTH-1` is illegal; a simulation assertion fires.

## Timing
- Stall/forward decisions have zero-cycle latency (combinational).
- An instruction issued at edge n occupies stage 0 during cycle n+1 and retires after edge n+`PIPE_DEPTH`.
- **Reset** (`rst` low, asynchronous, any time including mid-stream):
  - all `v=0`, `stall_count=0`;
  - hence `stall=0`, `fwd_hit=0`, `fwd_stage=0`, `busy=0` while in reset and after release.
- **Simultaneous events:**
  - `stall` and `squash` in the same cycle: the bubble wins (entry invalid either way).
  - A source matching a WB-stage entry forwards from stage `PIPE_DEPTH-1`; there is no stall for register-file write/read collision.
- **Back-to-back dependent ALU ops:** no stall; forward from stage 0.
- **Load-use:** exactly 1 stall cycle at `PIPE_DEPTH=3`; the next cycle forwards from stage 1.

## Structure
- Shared `pipeline_pkg` holds:
  - `clog2` function;
  - stage index constants `STAGE_EXE=0`, `STAGE_MEM=1`;
  - the `rdy` encoding per instruction type (ALU/load-imm = 0, load-mem = 1).
- One sub-module, `scoreboard_port_match`, instantiated `NUM_READ` times: a priority match of one source against the entry vector, returning `{hazard, hit, stage}`.

## Test plan
1. **Reset during activity:** drive traffic, pull `rst` low mid-stream → `busy=0`, `stall=0`, `stall_count=0` asynchronously; the first post-reset issue sees no hazards.
2. **ALU→ALU chain:** write r3 (rdy 0), then read r3 next cycle → `stall=0`, `fwd_hit[0]=1`, `fwd_stage=0`. The following cycle → stage 1. Then 2. Then `fwd_hit=0`.
3. **Load-use:** load r5 (rdy 1), next instruction reads r5 on port 1 → exactly 1 cycle of `stall=1` (`stall_count` +1), then `fwd_hit[1]=1`, `fwd_stage=1`.
4. **Youngest-wins:** r7 written by a load (rdy 1), then by an ALU op (rdy 0), then read → forward from stage 0, no stall despite the older unready load.
5. **Squash/flush:** issue a write r9 with `squash=1` → `busy[9]` never set. Three writers in flight, then `flush=1` → next cycle `busy=0`, and a reader of those registers sees no forward and no stall.
6. **R0 and saturation:** with `R0_ZERO=1`, write r0 then read r0 → no hit, `busy[0]=0`. Force `stall_count=32'hFFFF_FFFE` and stall 3 cycles → it holds at `FFFF_FFFF`.
